// File: rtl/toa_hit_buffer.sv
// Hit capture buffer behind the TOA encoder: BCID time-tagging, a first-word
// fall-through FIFO with a valid/ready readout port, and saturating statistics.
module toa_hit_buffer #(
    parameter int DEPTH  = 8,
    parameter int BCID_W = 6,
    parameter int CNT_W  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       hit_valid,
    input  logic [2:0]                 coarse_phase,
    input  logic [6:0]                 fine_phase,
    input  logic                       error_flag,
    input  logic                       drop_err,
    input  logic                       bx_strobe,
    input  logic                       bc_rst,
    input  logic                       stat_clr,
    output logic [BCID_W+10:0]         dout,
    output logic                       dout_valid,
    input  logic                       dout_ready,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       overflow,
    output logic [CNT_W-1:0]           err_count,
    output logic [CNT_W-1:0]           drop_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int DW = BCID_W + 11;
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];
    localparam logic [AW:0] ONE_CNT  = 1;

    // Readout handshake: a word transfers on any edge where dout_valid and
    // dout_ready are both high; dout/dout_valid hold while dout_ready is low.

    logic [DW-1:0]     mem [DEPTH];
    logic [AW-1:0]     rdPtr;
    logic [AW-1:0]     wrPtr;
    logic [AW-1:0]     rdPtrNext;
    logic [AW:0]       count;
    logic [BCID_W-1:0] bcid;
    logic [DW-1:0]     hitWord;
    logic              wrReq;
    logic              pop;
    logic              isFull;
    logic              wrAcc;
    logic              wrRej;
    logic              errHit;

    assign hitWord   = {bcid, error_flag, coarse_phase, fine_phase};
    assign errHit    = hit_valid & error_flag;
    assign wrReq     = hit_valid & ~(error_flag & drop_err);
    assign pop       = dout_valid & dout_ready;
    assign isFull    = (count == FULL_CNT);
    assign wrAcc     = wrReq & (~isFull | pop);
    assign wrRej     = wrReq & isFull & ~pop;
    assign rdPtrNext = rdPtr + 1'b1;
    assign fifo_count = count;

    // Storage holds every queued word, including the one mirrored on dout.
    always_ff @(posedge clk) begin
        if (wrAcc) begin
            mem[wrPtr] <= hitWord;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bcid       <= '0;
            rdPtr      <= '0;
            wrPtr      <= '0;
            count      <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            overflow   <= 1'b0;
            err_count  <= '0;
            drop_count <= '0;
        end else begin
            if (bc_rst) begin
                bcid <= '0;
            end else if (bx_strobe) begin
                bcid <= bcid + 1'b1;
            end

            if (wrAcc) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (pop) begin
                rdPtr <= rdPtr + 1'b1;
            end

            if (wrAcc && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !wrAcc) begin
                count <= count - 1'b1;
            end

            // Next head: the following stored word, or the incoming hit when
            // the buffer is (about to be) empty.
            if (pop) begin
                if (count != ONE_CNT) begin
                    dout <= mem[rdPtrNext];
                end else if (wrAcc) begin
                    dout <= hitWord;
                end
            end else if (count == '0 && wrAcc) begin
                dout <= hitWord;
            end

            if (wrAcc) begin
                dout_valid <= 1'b1;
            end else if (pop && count == ONE_CNT) begin
                dout_valid <= 1'b0;
            end

            if (stat_clr) begin
                err_count  <= '0;
                drop_count <= '0;
                overflow   <= 1'b0;
            end else begin
                if (errHit && err_count != '1) begin
                    err_count <= err_count + 1'b1;
                end
                if (wrRej) begin
                    overflow <= 1'b1;
                    if (drop_count != '1) begin
                        drop_count <= drop_count + 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_toa_hit_buffer.sv
// Randomized and directed bench for toa_hit_buffer against a queue-based model.
module tb_toa_hit_buffer;
    localparam int DEPTH  = 8;
    localparam int BCID_W = 6;
    localparam int CNT_W  = 8;
    localparam int DW     = BCID_W + 11;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              hitValid = 1'b0;
    logic [2:0]        coarsePhase = '0;
    logic [6:0]        finePhase = '0;
    logic              errorFlag = 1'b0;
    logic              dropErr = 1'b0;
    logic              bxStrobe = 1'b0;
    logic              bcRst = 1'b0;
    logic              statClr = 1'b0;
    logic [DW-1:0]     dout;
    logic              doutValid;
    logic              doutReady = 1'b0;
    logic [3:0]        fifoCount;
    logic              overflow;
    logic [CNT_W-1:0]  errCount;
    logic [CNT_W-1:0]  dropCount;

    int testCount = 0;
    int failCount = 0;

    // Reference model state
    logic [DW-1:0] expQ[$];
    int mBcid = 0;
    int mErr  = 0;
    int mDrop = 0;
    int mOvf  = 0;

    toa_hit_buffer #(.DEPTH(DEPTH), .BCID_W(BCID_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .hit_valid(hitValid), .coarse_phase(coarsePhase),
        .fine_phase(finePhase), .error_flag(errorFlag), .drop_err(dropErr),
        .bx_strobe(bxStrobe), .bc_rst(bcRst), .stat_clr(statClr),
        .dout(dout), .dout_valid(doutValid), .dout_ready(doutReady),
        .fifo_count(fifoCount), .overflow(overflow), .err_count(errCount),
        .drop_count(dropCount)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] act, input logic [31:0] exp);
        testCount++;
        if (act !== exp) begin
            failCount++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance the model with the current inputs, clock the DUT, compare all outputs.
    task automatic tick();
        logic [DW-1:0] word;
        logic [BCID_W-1:0] b;
        bit doPop;
        bit wasRst;
        wasRst = rst;
        if (rst) begin
            expQ.delete();
            mBcid = 0; mErr = 0; mDrop = 0; mOvf = 0;
        end else begin
            b = mBcid[BCID_W-1:0];
            word = {b, errorFlag, coarsePhase, finePhase};
            doPop = (expQ.size() > 0) && doutReady;
            if (hitValid && errorFlag && mErr < 255) mErr++;
            if (doPop) void'(expQ.pop_front());
            if (hitValid && !(errorFlag && dropErr)) begin
                if (expQ.size() < DEPTH) expQ.push_back(word);
                else begin
                    if (mDrop < 255) mDrop++;
                    mOvf = 1;
                end
            end
            if (statClr) begin
                mErr = 0; mDrop = 0; mOvf = 0;
            end
            if (bcRst) mBcid = 0;
            else if (bxStrobe) mBcid = (mBcid + 1) % (1 << BCID_W);
        end
        @(posedge clk);
        #1;
        checkVal("fifo_count", 32'(fifoCount), 32'(expQ.size()));
        checkVal("dout_valid", 32'(doutValid), 32'(expQ.size() > 0));
        if (expQ.size() > 0) checkVal("dout", 32'(dout), 32'(expQ[0]));
        else if (wasRst) checkVal("dout_rst", 32'(dout), 32'd0);
        checkVal("overflow", 32'(overflow), 32'(mOvf));
        checkVal("err_count", 32'(errCount), 32'(mErr));
        checkVal("drop_count", 32'(dropCount), 32'(mDrop));
        rst = 1'b0; hitValid = 1'b0; bxStrobe = 1'b0; bcRst = 1'b0; statClr = 1'b0;
    endtask

    task automatic hit(input logic [2:0] c, input logic [6:0] f, input logic e);
        hitValid = 1'b1; coarsePhase = c; finePhase = f; errorFlag = e;
        tick();
    endtask

    task automatic doReset();
        rst = 1'b1;
        tick();
    endtask

    task automatic drain();
        doutReady = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) tick();
        doutReady = 1'b0;
    endtask

    logic [DW-1:0] t1Word;

    initial begin
        // 1. Basic tagging
        doReset();
        for (int i = 0; i < 5; i++) begin bxStrobe = 1'b1; tick(); end
        hit(3'd5, 7'd100, 1'b0);
        t1Word = {6'd5, 1'b0, 3'd5, 7'd100};
        checkVal("t1_dout", 32'(dout), 32'(t1Word));
        checkVal("t1_count", 32'(fifoCount), 32'd1);
        doutReady = 1'b1; tick(); doutReady = 1'b0;
        checkVal("t1_empty", 32'(doutValid), 32'd0);

        // 2. Overflow, in-order drain, stat_clr
        doReset();
        for (int i = 1; i <= 10; i++) hit(3'd0, 7'(i), 1'b0);
        checkVal("t2_count", 32'(fifoCount), 32'd8);
        checkVal("t2_drop", 32'(dropCount), 32'd2);
        checkVal("t2_ovf", 32'(overflow), 32'd1);
        doutReady = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            checkVal("t2_order", 32'(dout[6:0]), 32'(i));
            tick();
        end
        doutReady = 1'b0;
        statClr = 1'b1; tick();
        checkVal("t2_clr_drop", 32'(dropCount), 32'd0);
        checkVal("t2_clr_ovf", 32'(overflow), 32'd0);

        // 3. Full with simultaneous push and pop
        for (int i = 0; i < 8; i++) hit(3'd1, 7'(i), 1'b0);
        doutReady = 1'b1;
        hit(3'd2, 7'd77, 1'b0);
        doutReady = 1'b0;
        checkVal("t3_count", 32'(fifoCount), 32'd8);
        checkVal("t3_drop", 32'(dropCount), 32'd0);
        drain();

        // 4. Error filtering
        doReset();
        dropErr = 1'b1;
        for (int i = 0; i < 3; i++) hit(3'd0, 7'h3F, 1'b1);
        checkVal("t4_err3", 32'(errCount), 32'd3);
        checkVal("t4_cnt0", 32'(fifoCount), 32'd0);
        dropErr = 1'b0;
        for (int i = 0; i < 3; i++) hit(3'd0, 7'h3F, 1'b1);
        checkVal("t4_err6", 32'(errCount), 32'd6);
        checkVal("t4_cnt3", 32'(fifoCount), 32'd3);
        checkVal("t4_bit10", 32'(dout[10]), 32'd1);
        drain();

        // 5. BCID wrap and priority
        doReset();
        for (int i = 0; i < 64; i++) begin bxStrobe = 1'b1; tick(); end
        hit(3'd0, 7'd1, 1'b0);
        checkVal("t5_wrap", 32'(dout[16:11]), 32'd0);
        drain();
        bcRst = 1'b1; tick();
        for (int i = 0; i < 17; i++) begin bxStrobe = 1'b1; tick(); end
        bcRst = 1'b1; bxStrobe = 1'b1; tick();
        hit(3'd0, 7'd2, 1'b0);
        checkVal("t5_prio", 32'(dout[16:11]), 32'd0);
        drain();
        bcRst = 1'b1; tick();
        for (int i = 0; i < 9; i++) begin bxStrobe = 1'b1; tick(); end
        bxStrobe = 1'b1;
        hit(3'd0, 7'd3, 1'b0);
        checkVal("t5_pre", 32'(dout[16:11]), 32'd9);
        drain();

        // 6. Reset mid-operation
        for (int i = 0; i < 5; i++) begin bxStrobe = 1'b1; tick(); end
        dropErr = 1'b0;
        for (int i = 0; i < 4; i++) hit(3'd3, 7'(i), 1'b1);
        doReset();
        checkVal("t6_count", 32'(fifoCount), 32'd0);
        checkVal("t6_valid", 32'(doutValid), 32'd0);
        checkVal("t6_err", 32'(errCount), 32'd0);
        hit(3'd4, 7'd55, 1'b0);
        checkVal("t6_valid1", 32'(doutValid), 32'd1);
        checkVal("t6_bcid", 32'(dout[16:11]), 32'd0);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            rst         = ($urandom_range(0, 199) == 0);
            hitValid    = ($urandom_range(0, 99) < 55);
            coarsePhase = 3'($urandom);
            finePhase   = 7'($urandom);
            errorFlag   = ($urandom_range(0, 3) == 0);
            bxStrobe    = ($urandom_range(0, 1) == 1);
            bcRst       = ($urandom_range(0, 49) == 0);
            statClr     = ($urandom_range(0, 99) == 0);
            doutReady   = ($urandom_range(0, 99) < 45);
            if ($urandom_range(0, 99) == 0) dropErr = ~dropErr;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end
endmodule

// File: doc/toa_hit_buffer.md
Name: toa_hit_buffer

Overview:
- Capture stage directly downstream of the TOA encoder.
- On each hit strobe, latches the encoder's coarse phase, fine phase and error flag, and time-tags the hit with a local bunch-crossing counter.
- Queues tagged hits in a small FIFO and presents them to the readout through a valid/ready handshake.
- Keeps saturating error and drop statistics for slow control.

Parameters:
- DEPTH, 8, FIFO entries; power of two, 2..64.
- BCID_W, 6, bunch-crossing counter width; 1..12.
- CNT_W, 8, width of the statistics counters.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- hit_valid  in  1  one-cycle strobe; encoder outputs are stable this cycle.
- coarse_phase  in  3  encoder coarse phase.
- fine_phase  in  7  encoder fine phase.
- error_flag  in  1  encoder error flag.
- drop_err  in  1  static config; 1 = discard hits with error_flag=1.
- bx_strobe  in  1  advances the BCID counter.
- bc_rst  in  1  clears the BCID counter.
- stat_clr  in  1  clears the statistics counters and the overflow flag.
- dout  out  BCID_W+11  {bcid, error_flag, coarse_phase, fine_phase}, MSB first.
- dout_valid  out  1  dout holds a word.
- dout_ready  in  1  consumer accepts the word.
- fifo_count  out  clog2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky: a hit was dropped because the FIFO was full.
- err_count  out  CNT_W  hits seen with error_flag=1, saturating.
- drop_count  out  CNT_W  hits lost to a full FIFO, saturating.

Behaviour:
- Reset: while rst=1 at a clk edge, the following are cleared and stay clear until the first edge with rst=0:
  - BCID counter, FIFO pointers, fifo_count=0
  - dout_valid=0, dout=0
  - overflow=0, err_count=0, drop_count=0
  - In-flight hits and queued data are discarded.
- BCID counter:
  - bc_rst=1 sets it to 0; bc_rst has priority over bx_strobe.
  - Otherwise bx_strobe increments it modulo 2^BCID_W, so all-ones wraps to 0.
  - A hit is tagged with the counter value *before* any update in the same cycle.
- Hit qualification, in the cycle with hit_valid=1:
  - If error_flag=1: err_count increments (saturates at all-ones), independent of drop_err and FIFO state.
  - If error_flag=1 and drop_err=1: the hit is discarded; no FIFO write, no drop_count change.
  - Otherwise the hit is a write request.
- Write:
  - Accepted if fifo_count<DEPTH, or if fifo_count==DEPTH and a pop occurs in the same cycle.
  - Rejected otherwise: drop_count increments (saturating) and overflow is set.
- Pop: occurs when dout_valid=1 and dout_ready=1.
  - fifo_count changes by +1, −1, or 0 (simultaneous push and pop).
- Output register, first-word fall-through:
  - A word written into an empty buffer appears on dout with dout_valid=1 on the next edge (latency 1 cycle).
  - dout and dout_valid hold stable while dout_valid=1 and dout_ready=0.
  - After a pop, the next queued word is presented on the following edge with no bubble.
  - dout_valid drops to 0 only when the buffer empties.
  - fifo_count includes the word shown on dout.
- dout_ready is ignored while dout_valid=0.
- stat_clr clears err_count, drop_count and overflow.
  - If an increment coincides with stat_clr, the clear wins; the counter reads 0.
  - stat_clr does not affect FIFO contents or the BCID counter.
- Order is strict FIFO; no reordering. Pointers wrap modulo DEPTH.
- Inputs are sampled only when hit_valid=1; coarse_phase, fine_phase and error_flag are don't-care otherwise.

Test Plan:
1. Basic tagging: rst, then 5 bx_strobe pulses, then hit_valid with coarse=3'd5, fine=7'd100, err=0 → next cycle dout_valid=1, dout={6'd5,1'b0,3'd5,7'd100}, fifo_count=1; dout_ready=1 → count=0, dout_valid=0.
2. Overflow (DEPTH=8, dout_ready=0): 10 hits → fifo_count=8, drop_count=2, overflow=1. Drain 8 words → fine values match hits 1..8 in order. stat_clr → drop_count=0, overflow=0.
3. Full with simultaneous push and pop: fill to 8; hold dout_ready=1 while hit_valid=1 → write accepted, count stays 8, drop_count unchanged.
4. Error filtering: 3 hits with error_flag=1, fine=7'h3F. With drop_err=1 → err_count=3, fifo_count=0. With drop_err=0 → err_count=6, fifo_count=3, dout bit 10=1.
5. BCID wrap and priority: 64 bx_strobe from 0 → hit tagged bcid=0. bc_rst and bx_strobe together at bcid=17 → next bcid=0. Hit in the same cycle as a bx_strobe at bcid=9 → tagged 9.
6. Reset mid-operation: 4 words queued with dout_valid=1, then a 1-cycle rst → fifo_count=0, dout_valid=0, counters 0. Next hit is tagged bcid=0 and appears after 1 cycle.
